// File: rtl/dino_score_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dino_score_pkg
//  Purpose  : Shared constants and types for the dino runner score keeper.
//             A score is four packed BCD digits, ones digit in [3:0].
//  Revision : 1.0 - initial release
// ============================================================================
package dino_score_pkg;

  localparam int BCD_W        = 4;
  localparam int SCORE_DIGITS = 4;

  typedef logic [BCD_W*SCORE_DIGITS-1:0] bcd_score_t;

  localparam bcd_score_t SCORE_MAX = 16'h9999;

endpackage : dino_score_pkg
`default_nettype wire

// File: rtl/bcd_counter4.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_counter4
//  Purpose  : Four-digit packed BCD incrementer that saturates at 9999.
//  Ports    : clk           - clock, rising edge
//             reset         - asynchronous active-high clear
//             clr           - synchronous clear, wins over inc
//             inc           - add one point (ignored at saturation)
//             q             - current count, packed BCD
//             at_max        - count is 9999
//             hundreds_roll - the next inc lands on a nonzero multiple of 100
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_counter4
  import dino_score_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output bcd_score_t q,
  output logic       at_max,
  output logic       hundreds_roll
);

  bcd_score_t  q_q;
  bcd_score_t  q_d;
  logic        carry;
  logic [3:0]  digit;

  assign at_max = (q_q == SCORE_MAX);
  // Low two digits at 99 means the next increment carries into the hundreds;
  // the result is then >= 100 and therefore nonzero.
  assign hundreds_roll = (q_q[7:0] == 8'h99) && !at_max;
  assign q = q_q;

  // Ripple the carry from the ones digit upward; a digit passing 9 wraps to 0.
  always_comb begin
    q_d   = q_q;
    carry = inc && !at_max;
    digit = '0;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      digit = q_q[i*BCD_W +: BCD_W];
      if (carry) begin
        if (digit == 4'd9) begin
          q_d[i*BCD_W +: BCD_W] = 4'd0;
        end else begin
          q_d[i*BCD_W +: BCD_W] = digit + 4'd1;
          carry = 1'b0;
        end
      end
    end
    if (clr) begin
      q_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule : bcd_counter4
`default_nettype wire

// File: rtl/score_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : score_tracker
//  Purpose  : Run score accumulation, high score commit on death, display
//             digit selection and a 100-point milestone pulse.
//  Ports    : clk_100Hz       - 100 Hz game clock
//             reset           - asynchronous active-high, clears everything
//             enable          - game running
//             dead            - hero dead (level)
//             restart         - synchronous new game, keeps the high score
//             show_high_pulse - toggles the display selection
//             cur_score       - current score, packed BCD
//             high_score      - high score, packed BCD
//             disp_d0..d3     - selected score digits, d0 = ones
//             show_high       - display selection (1 = high score)
//             new_record      - last death set a new high score
//             milestone       - one-cycle pulse at each nonzero multiple of 100
//  Revision : 1.0 - initial release
// ============================================================================
module score_tracker
  import dino_score_pkg::*;
#(
  parameter int unsigned TICKS_PER_POINT = 10
)(
  input  logic        clk_100Hz,
  input  logic        reset,
  input  logic        enable,
  input  logic        dead,
  input  logic        restart,
  input  logic        show_high_pulse,
  output logic [15:0] cur_score,
  output logic [15:0] high_score,
  output logic [3:0]  disp_d0,
  output logic [3:0]  disp_d1,
  output logic [3:0]  disp_d2,
  output logic [3:0]  disp_d3,
  output logic        show_high,
  output logic        new_record,
  output logic        milestone
);

  localparam logic [7:0] TICK_LAST = 8'(TICKS_PER_POINT - 1);

  logic [7:0]  tick_cnt_q, tick_cnt_d;
  logic        dead_q, dead_d;
  bcd_score_t  high_score_q, high_score_d;
  logic        show_high_q, show_high_d;
  logic        new_record_q, new_record_d;
  logic        milestone_q, milestone_d;

  logic        run;
  logic        inc;
  logic        cnt_inc;
  logic        dead_rise;
  logic        at_max;
  logic        hundreds_roll;
  bcd_score_t  score;
  bcd_score_t  disp;

  assign run       = enable && !dead;
  assign inc       = run && (tick_cnt_q == TICK_LAST);
  // restart beats a coincident point increment
  assign cnt_inc   = inc && !restart && !at_max;
  assign dead_rise = dead && !dead_q;

  bcd_counter4 u_counter (
    .clk           (clk_100Hz),
    .reset         (reset),
    .clr           (restart),
    .inc           (cnt_inc),
    .q             (score),
    .at_max        (at_max),
    .hundreds_roll (hundreds_roll)
  );

  always_comb begin
    tick_cnt_d   = tick_cnt_q;
    dead_d       = dead;
    high_score_d = high_score_q;
    new_record_d = new_record_q;
    show_high_d  = show_high_q ^ show_high_pulse;
    milestone_d  = cnt_inc && hundreds_roll;

    // Prescaler holds while paused so partial progress survives a pause.
    if (restart) begin
      tick_cnt_d = '0;
    end else if (run) begin
      tick_cnt_d = (tick_cnt_q == TICK_LAST) ? 8'd0 : tick_cnt_q + 8'd1;
    end

    // Compare against the pre-clear score so a death coinciding with
    // restart still commits the score that was just earned.
    if (dead_rise) begin
      if (score > high_score_q) begin
        high_score_d = score;
        new_record_d = 1'b1;
      end else begin
        new_record_d = 1'b0;
      end
    end

    if (restart) begin
      new_record_d = 1'b0;
    end
  end

  always_ff @(posedge clk_100Hz or posedge reset) begin
    if (reset) begin
      tick_cnt_q   <= '0;
      dead_q       <= 1'b0;
      high_score_q <= '0;
      show_high_q  <= 1'b0;
      new_record_q <= 1'b0;
      milestone_q  <= 1'b0;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      dead_q       <= dead_d;
      high_score_q <= high_score_d;
      show_high_q  <= show_high_d;
      new_record_q <= new_record_d;
      milestone_q  <= milestone_d;
    end
  end

  assign disp       = show_high_q ? high_score_q : score;
  assign cur_score  = score;
  assign high_score = high_score_q;
  assign show_high  = show_high_q;
  assign new_record = new_record_q;
  assign milestone  = milestone_q;
  assign disp_d0    = disp[3:0];
  assign disp_d1    = disp[7:4];
  assign disp_d2    = disp[11:8];
  assign disp_d3    = disp[15:12];

endmodule : score_tracker
`default_nettype wire

// File: tb/tb_score_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_score_tracker
//  Purpose  : Directed self-checking bench for score_tracker. A second
//             instance with one tick per point reaches the carry, milestone
//             and saturation corners in a short run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_score_tracker;

  logic        clk_100Hz = 1'b0;
  logic        reset     = 1'b1;

  logic        enable = 1'b0, dead = 1'b0, restart = 1'b0, show_high_pulse = 1'b0;
  logic [15:0] cur_score, high_score;
  logic [3:0]  disp_d0, disp_d1, disp_d2, disp_d3;
  logic        show_high, new_record, milestone;

  logic        enable_f = 1'b0, dead_f = 1'b0, restart_f = 1'b0, pulse_f = 1'b0;
  logic [15:0] cur_f, high_f;
  logic [3:0]  d0_f, d1_f, d2_f, d3_f;
  logic        show_f, nr_f, ms_f;

  int vectors   = 0;
  int miscmp    = 0;
  int ms_main_n = 0;
  int ms_fast_n = 0;

  always #5 clk_100Hz = ~clk_100Hz;

  score_tracker #(.TICKS_PER_POINT(10)) dut (
    .clk_100Hz(clk_100Hz), .reset(reset), .enable(enable), .dead(dead),
    .restart(restart), .show_high_pulse(show_high_pulse),
    .cur_score(cur_score), .high_score(high_score),
    .disp_d0(disp_d0), .disp_d1(disp_d1), .disp_d2(disp_d2), .disp_d3(disp_d3),
    .show_high(show_high), .new_record(new_record), .milestone(milestone)
  );

  score_tracker #(.TICKS_PER_POINT(1)) dut_fast (
    .clk_100Hz(clk_100Hz), .reset(reset), .enable(enable_f), .dead(dead_f),
    .restart(restart_f), .show_high_pulse(pulse_f),
    .cur_score(cur_f), .high_score(high_f),
    .disp_d0(d0_f), .disp_d1(d1_f), .disp_d2(d2_f), .disp_d3(d3_f),
    .show_high(show_f), .new_record(nr_f), .milestone(ms_f)
  );

  always @(negedge clk_100Hz) begin
    if (milestone) ms_main_n++;
    if (ms_f)      ms_fast_n++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
      else begin
        miscmp++;
        $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_100Hz);
  endtask

  initial begin
    // ---- reset state ----
    #2;
    check("rst_cur",  {16'h0, cur_score}, 32'h0);
    check("rst_high", {16'h0, high_score}, 32'h0);
    check("rst_flags", {29'h0, show_high, new_record, milestone}, 32'h0);
    check("rst_disp", {16'h0, disp_d3, disp_d2, disp_d1, disp_d0}, 32'h0);

    // ---- fast instance: carry, milestone, saturation ----
    step(1);
    reset    = 1'b0;
    enable_f = 1'b1;
    step(99);
    check("f_0099", {16'h0, cur_f}, 32'h0099);
    check("f_no_ms_before_100", ms_fast_n, 0);
    step(1);
    check("f_0100", {16'h0, cur_f}, 32'h0100);
    check("f_ms_at_100", {31'h0, ms_f}, 32'h1);
    step(1);
    check("f_ms_one_cycle", {31'h0, ms_f}, 32'h0);
    check("f_ms_count_1", ms_fast_n, 1);
    step(898);
    check("f_0999", {16'h0, cur_f}, 32'h0999);
    step(1);
    check("f_1000", {16'h0, cur_f}, 32'h1000);
    check("f_ms_at_1000", {31'h0, ms_f}, 32'h1);
    step(8999);
    check("f_9999", {16'h0, cur_f}, 32'h9999);
    check("f_ms_count_99", ms_fast_n, 99);
    step(50);
    check("f_sat_hold", {16'h0, cur_f}, 32'h9999);
    check("f_sat_no_ms", ms_fast_n, 99);
    enable_f = 1'b0;

    // ---- basic count ----
    enable = 1'b1;
    step(105);
    check("basic_0010", {16'h0, cur_score}, 32'h0010);
    check("basic_no_ms", ms_main_n, 0);

    // ---- pause keeps prescaler progress ----
    enable  = 1'b0;
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    check("restart_clr", {16'h0, cur_score}, 32'h0);
    enable = 1'b1; step(15);
    enable = 1'b0; step(50);
    check("pause_hold", {16'h0, cur_score}, 32'h0001);
    enable = 1'b1; step(5);
    check("pause_0002", {16'h0, cur_score}, 32'h0002);

    // ---- first high score ----
    enable  = 1'b0;
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    enable  = 1'b1;
    step(420);
    check("run_0042", {16'h0, cur_score}, 32'h0042);
    dead = 1'b1;
    step(1);
    check("hs_0042", {16'h0, high_score}, 32'h0042);
    check("nr_set", {31'h0, new_record}, 32'h1);
    step(5);
    check("dead_freeze", {16'h0, cur_score}, 32'h0042);

    // ---- lower score does not replace it (restart while dead) ----
    restart = 1'b1;
    enable  = 1'b0;
    step(1);
    restart = 1'b0;
    dead    = 1'b0;
    check("restart_nr_clr", {31'h0, new_record}, 32'h0);
    check("restart_keeps_hs", {16'h0, high_score}, 32'h0042);
    enable = 1'b1;
    step(300);
    check("run_0030", {16'h0, cur_score}, 32'h0030);
    dead = 1'b1;
    step(1);
    check("hs_kept", {16'h0, high_score}, 32'h0042);
    check("nr_low", {31'h0, new_record}, 32'h0);

    // ---- death edge and restart in the same cycle ----
    dead    = 1'b0;
    enable  = 1'b0;
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    enable  = 1'b1;
    step(770);
    check("run_0077", {16'h0, cur_score}, 32'h0077);
    dead    = 1'b1;
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    check("simul_hs", {16'h0, high_score}, 32'h0077);
    check("simul_cur", {16'h0, cur_score}, 32'h0);

    // ---- display toggle ----
    dead   = 1'b0;
    enable = 1'b0;
    show_high_pulse = 1'b1;
    step(1);
    show_high_pulse = 1'b0;
    check("show_high_set", {31'h0, show_high}, 32'h1);
    check("disp_high", {16'h0, disp_d3, disp_d2, disp_d1, disp_d0}, 32'h0077);
    step(3);
    check("show_high_held", {31'h0, show_high}, 32'h1);

    // ---- async reset mid-run ----
    enable = 1'b1;
    step(25);
    check("pre_reset_cur", {16'h0, cur_score}, 32'h0002);
    #2 reset = 1'b1;
    #1;
    check("arst_cur",  {16'h0, cur_score}, 32'h0);
    check("arst_high", {16'h0, high_score}, 32'h0);
    check("arst_flags", {29'h0, show_high, new_record, milestone}, 32'h0);
    check("arst_disp", {16'h0, disp_d3, disp_d2, disp_d1, disp_d0}, 32'h0);
    check("arst_fast", {16'h0, cur_f}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
    $finish;
  end

endmodule : tb_score_tracker
`default_nettype wire
